// File: rtl/traffic_phase_sequencer.sv
// Four-approach signal sequencer: N->E->S->W through GREEN, YELLOW and ALL_RED,
// with per-road green time clamped and sampled at green entry; empty roads optionally skipped.

module tps_lamp #(
  parameter logic [1:0] ROAD = 2'd0
) (
  input  logic [1:0] cur_road,
  input  logic       in_green,
  input  logic       in_yellow,
  output logic [2:0] lamp
);
  always_comb begin
    lamp = 3'b100;
    if (cur_road == ROAD) begin
      if (in_green)       lamp = 3'b001;
      else if (in_yellow) lamp = 3'b010;
    end
  end
endmodule

module traffic_phase_sequencer #(
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 60,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int SKIP_EMPTY  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] TGn,
  input  logic [7:0] TGe,
  input  logic [7:0] TGs,
  input  logic [7:0] TGw,
  output logic [1:0] next_road,
  output logic [1:0] cur_road,
  output logic [2:0] light_n,
  output logic [2:0] light_e,
  output logic [2:0] light_s,
  output logic [2:0] light_w,
  output logic       phase_start,
  output logic [7:0] timer
);
  localparam int          NUM_ROADS = 4;
  localparam logic [1:0]  S_GREEN   = 2'd0;
  localparam logic [1:0]  S_YELLOW  = 2'd1;
  localparam logic [1:0]  S_ALLRED  = 2'd2;
  localparam logic [7:0]  MIN8      = 8'(MIN_GREEN);
  localparam logic [7:0]  MAX8      = 8'(MAX_GREEN);
  localparam logic [7:0]  YEL8      = 8'(YELLOW_TIME);
  localparam logic [7:0]  AR8       = 8'(ALLRED_TIME);

  logic [1:0]                     state;
  logic [NUM_ROADS-1:0][7:0]      tg;
  logic [NUM_ROADS-1:0][2:0]      lamps;
  logic [1:0]                     sel;
  logic [1:0]                     cand;
  logic                           found;
  logic [7:0]                     tg_sel;
  logic [7:0]                     g_dur;

  assign tg = {TGw, TGs, TGe, TGn};

  // Rotation order cur+1..cur+3 then cur itself; all-empty falls back to cur+1.
  always_comb begin
    sel   = cur_road + 2'd1;
    cand  = '0;
    found = 1'b0;
    if (SKIP_EMPTY != 0) begin
      for (int k = 1; k <= NUM_ROADS; k++) begin
        cand = cur_road + 2'(k);
        if (!found && tg[cand] != 8'd0) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign next_road = sel;
  assign tg_sel    = tg[sel];
  assign g_dur     = (tg_sel < MIN8) ? MIN8 : ((tg_sel > MAX8) ? MAX8 : tg_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_ALLRED;
      cur_road    <= 2'd3;
      timer       <= AR8;
      phase_start <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      if (tick) begin
        if (timer > 8'd1) begin
          timer <= timer - 8'd1;
        end else begin
          case (state)
            S_GREEN: begin
              state <= S_YELLOW;
              timer <= YEL8;
            end
            S_YELLOW: begin
              state <= S_ALLRED;
              timer <= AR8;
            end
            default: begin
              state       <= S_GREEN;
              cur_road    <= sel;
              timer       <= g_dur;
              phase_start <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_lamp
    tps_lamp #(.ROAD(2'(r))) u_lamp (
      .cur_road  (cur_road),
      .in_green  (state == S_GREEN),
      .in_yellow (state == S_YELLOW),
      .lamp      (lamps[r])
    );
  end

  assign light_n = lamps[0];
  assign light_e = lamps[1];
  assign light_s = lamps[2];
  assign light_w = lamps[3];
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: vector table, directed phase-length sequences,
// and random traffic against a phase/remaining-ticks reference model.

module tb_traffic_phase_sequencer;
  localparam int GR = 0, YE = 1, AR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] tgn = 8'd10, tge = 8'd10, tgs = 8'd10, tgw = 8'd10;
  logic [1:0] next_road, cur_road;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic       phase_start;
  logic [7:0] timer;
  logic [11:0] lights;

  int checks = 0;
  int errors = 0;

  int m_phase = AR, m_road = 3, m_rem = 1, m_ps = 0;

  traffic_phase_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick),
    .TGn(tgn), .TGe(tge), .TGs(tgs), .TGw(tgw),
    .next_road(next_road), .cur_road(cur_road),
    .light_n(light_n), .light_e(light_e), .light_s(light_s), .light_w(light_w),
    .phase_start(phase_start), .timer(timer)
  );

  assign lights = {light_n, light_e, light_s, light_w};

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int tg_of(int r);
    case (r)
      0: return int'(tgn);
      1: return int'(tge);
      2: return int'(tgs);
      default: return int'(tgw);
    endcase
  endfunction

  function automatic int pick_next(int cur);
    for (int k = 1; k <= 4; k++)
      if (tg_of((cur + k) % 4) != 0) return (cur + k) % 4;
    return (cur + 1) % 4;
  endfunction

  function automatic int clamp_g(int v);
    if (v < 5) return 5;
    if (v > 60) return 60;
    return v;
  endfunction

  function automatic logic [11:0] lamp_pat(int ph, int road);
    logic [11:0] p;
    logic [2:0]  c;
    p = '0;
    for (int r = 0; r < 4; r++) begin
      c = (ph != AR && r == road) ? ((ph == GR) ? 3'b001 : 3'b010) : 3'b100;
      p[(3-r)*3 +: 3] = c;
    end
    return p;
  endfunction

  // One clock: reference model advances on the edge, outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_phase = AR; m_road = 3; m_rem = 1; m_ps = 0;
    end else begin
      m_ps = 0;
      if (tick) begin
        if (m_rem > 1) m_rem--;
        else if (m_phase == GR) begin m_phase = YE; m_rem = 3; end
        else if (m_phase == YE) begin m_phase = AR; m_rem = 1; end
        else begin
          m_road  = pick_next(m_road);
          m_phase = GR;
          m_rem   = clamp_g(tg_of(m_road));
          m_ps    = 1;
        end
      end
    end
    #1;
  endtask

  task automatic check_model();
    chk("rnd_cur", int'(cur_road), m_road);
    chk("rnd_timer", int'(timer), m_rem);
    chk("rnd_lights", int'(lights), int'(lamp_pat(m_phase, m_road)));
    chk("rnd_next", int'(next_road), pick_next(m_road));
    chk("rnd_ps", int'(phase_start), m_ps);
  endtask

  task automatic set_tg(input int n, input int e, input int s, input int w);
    tgn = 8'(n); tge = 8'(e); tgs = 8'(s); tgw = 8'(w);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic run_phase(input string name, input logic [11:0] pat, input int exp_len);
    int cnt;
    cnt = 0;
    while (lights == pat && cnt < 300) begin
      cnt++;
      step();
    end
    chk(name, cnt, exp_len);
  endtask

  typedef struct {
    logic        rst, tk;
    logic [7:0]  n, e, s, w;
    int          cur, tmr;
    logic [11:0] lts;
    int          nxt, ps;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(logic rst, logic tk, int n, int e, int s, int w,
                              int cur, int tmr, logic [11:0] lts, int nxt, int ps);
    vec_t v;
    v.rst = rst; v.tk = tk; v.n = 8'(n); v.e = 8'(e); v.s = 8'(s); v.w = 8'(w);
    v.cur = cur; v.tmr = tmr; v.lts = lts; v.nxt = nxt; v.ps = ps;
    return v;
  endfunction

  initial begin
    int bad;
    int guard;

    vt[0]  = mk(1, 0,  10, 10, 10, 10, 3, 1,  lamp_pat(AR, 3), 0, 0);
    vt[1]  = mk(1, 1,  10, 10, 10, 10, 3, 1,  lamp_pat(AR, 3), 0, 0);
    vt[2]  = mk(0, 0,  10, 10, 10, 10, 3, 1,  lamp_pat(AR, 3), 0, 0);
    vt[3]  = mk(0, 1,  10, 10, 10, 10, 0, 10, lamp_pat(GR, 0), 1, 1);
    vt[4]  = mk(0, 0,  10, 10, 10, 10, 0, 10, lamp_pat(GR, 0), 1, 0);
    vt[5]  = mk(0, 1,  10, 10, 10, 10, 0, 9,  lamp_pat(GR, 0), 1, 0);
    vt[6]  = mk(1, 1,  10, 10, 10, 10, 3, 1,  lamp_pat(AR, 3), 0, 0);
    vt[7]  = mk(0, 1,  2,  10, 10, 10, 0, 5,  lamp_pat(GR, 0), 1, 1);
    vt[8]  = mk(0, 0,  2,  0,  0,  8,  0, 5,  lamp_pat(GR, 0), 3, 0);
    vt[9]  = mk(0, 0,  0,  0,  0,  0,  0, 5,  lamp_pat(GR, 0), 1, 0);
    vt[10] = mk(0, 1,  200, 10, 10, 10, 0, 4, lamp_pat(GR, 0), 1, 0);

    for (int i = 0; i < 11; i++) begin
      reset = vt[i].rst; tick = vt[i].tk;
      tgn = vt[i].n; tge = vt[i].e; tgs = vt[i].s; tgw = vt[i].w;
      step();
      chk($sformatf("vec%0d_cur", i),    int'(cur_road),    vt[i].cur);
      chk($sformatf("vec%0d_timer", i),  int'(timer),       vt[i].tmr);
      chk($sformatf("vec%0d_lights", i), int'(lights),      int'(vt[i].lts));
      chk($sformatf("vec%0d_next", i),   int'(next_road),   vt[i].nxt);
      chk($sformatf("vec%0d_ps", i),     int'(phase_start), vt[i].ps);
    end

    // Basic cycle with all roads at 10
    set_tg(10, 10, 10, 10);
    do_reset();
    chk("t1_reset_ps", int'(phase_start), 0);
    run_phase("t1_allred0", lamp_pat(AR, 3), 1);
    chk("t1_ps_n", int'(phase_start), 1);
    step();
    chk("t1_ps_n_drop", int'(phase_start), 0);
    run_phase("t1_n_green", lamp_pat(GR, 0), 9);
    run_phase("t1_n_yellow", lamp_pat(YE, 0), 3);
    run_phase("t1_allred1", lamp_pat(AR, 0), 1);
    chk("t1_e_green", int'(lights), int'(lamp_pat(GR, 1)));
    chk("t1_ps_e", int'(phase_start), 1);

    // Min/max clamp
    set_tg(2, 200, 10, 10);
    do_reset();
    run_phase("t2_allred0", lamp_pat(AR, 3), 1);
    run_phase("t2_n_green_min", lamp_pat(GR, 0), 5);
    run_phase("t2_n_yellow", lamp_pat(YE, 0), 3);
    run_phase("t2_allred1", lamp_pat(AR, 0), 1);
    run_phase("t2_e_green_max", lamp_pat(GR, 1), 60);

    // Skip empty roads: N,W alternate
    set_tg(8, 0, 0, 8);
    do_reset();
    run_phase("t3_allred0", lamp_pat(AR, 3), 1);
    chk("t3_next_during_n", int'(next_road), 3);
    run_phase("t3_n_green", lamp_pat(GR, 0), 8);
    run_phase("t3_n_yellow", lamp_pat(YE, 0), 3);
    run_phase("t3_allred1", lamp_pat(AR, 0), 1);
    run_phase("t3_w_green", lamp_pat(GR, 3), 8);
    run_phase("t3_w_yellow", lamp_pat(YE, 3), 3);
    run_phase("t3_allred2", lamp_pat(AR, 3), 1);
    chk("t3_back_to_n", int'(lights), int'(lamp_pat(GR, 0)));

    // All empty: plain rotation at MIN_GREEN
    set_tg(0, 0, 0, 0);
    do_reset();
    run_phase("t4_allred0", lamp_pat(AR, 3), 1);
    run_phase("t4_n_green", lamp_pat(GR, 0), 5);
    run_phase("t4_n_yellow", lamp_pat(YE, 0), 3);
    run_phase("t4_allred1", lamp_pat(AR, 0), 1);
    run_phase("t4_e_green", lamp_pat(GR, 1), 5);
    run_phase("t4_e_yellow", lamp_pat(YE, 1), 3);
    run_phase("t4_allred2", lamp_pat(AR, 1), 1);
    chk("t4_s_green", int'(lights), int'(lamp_pat(GR, 2)));

    // tick held low mid-green
    set_tg(10, 10, 10, 10);
    do_reset();
    step();
    repeat (3) step();
    chk("t5_timer_before", int'(timer), 7);
    tick = 1'b0;
    bad = 0;
    repeat (50) begin
      step();
      if (timer != 8'd7 || lights != lamp_pat(GR, 0) || cur_road != 2'd0) bad++;
    end
    chk("t5_frozen_cycles_bad", bad, 0);
    tick = 1'b1;
    run_phase("t5_remaining", lamp_pat(GR, 0), 7);

    // Reset during E green at timer=4
    do_reset();
    run_phase("t6_allred0", lamp_pat(AR, 3), 1);
    run_phase("t6_n_green", lamp_pat(GR, 0), 10);
    run_phase("t6_n_yellow", lamp_pat(YE, 0), 3);
    run_phase("t6_allred1", lamp_pat(AR, 0), 1);
    guard = 0;
    while (timer != 8'd4 && guard < 20) begin
      guard++;
      step();
    end
    chk("t6_reached_t4", int'(timer), 4);
    reset = 1'b1;
    step();
    chk("t6_lights", int'(lights), int'(lamp_pat(AR, 3)));
    chk("t6_cur", int'(cur_road), 3);
    chk("t6_timer", int'(timer), 1);
    reset = 1'b0;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        tgn = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        tge = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        tgs = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        tgw = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      tick  = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 299) == 0);
      step();
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
